ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter for the keyboard path. Clocked by the 50 MHz keyboard PLL output and gated by the PLL lock flag.
- Sends one command byte to the keyboard (reset 0xFF, set-LEDs 0xED, enable 0xF4) using the PS/2 request-to-send sequence: odd parity, stop bit, device ACK check, timeout.
- Drives the open-collector PS/2 lines through active-high pull-low enables. The top level builds the tri-states.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 176 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, keyboard command bytes and
// default timing for a 50 MHz system clock.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      DATA,
      PARITY,
      STOP,
      ACK
   } state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us
   localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms
   localparam int DEF_SYNC_STAGES    = 2;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings both raw PS/2 lines into the clk domain and flags falling edges of the
// PS/2 clock. Also used by the keyboard receiver.
module ps2_line_sync
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_line,
   output logic data_line,
   output logic clk_fall
);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;

   always_ff @(posedge clk) begin
      // NOTE: sync flops reset to the idle-high bus level so leaving reset never fakes a falling edge.
      if (!rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign clk_line  = clk_sync[SYNC_STAGES-1];
   assign data_line = data_sync[SYNC_STAGES-1];
   assign clk_fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 8 data bits LSB first,
// odd parity, stop, device ACK check, with timeout and PLL-lock abort.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       locked,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             parity_q, parity_d;
   logic [2:0]       idx_q, idx_d;
   logic             ready_d, done_d, err_d, clk_oe_d, data_oe_d;
   logic             abort;
   logic             clk_line, data_line, clk_fall;

   ps2_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .clk_line    (clk_line),
      .data_line   (data_line),
      .clk_fall    (clk_fall)
   );

   // NOTE: outputs are registered from the next-state decode, so reset drives every output low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         idx_q       <= '0;
         tx_ready    <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         idx_q       <= idx_d;
         tx_ready    <= ready_d;
         tx_done     <= done_d;
         tx_err      <= err_d;
         ps2_clk_oe  <= clk_oe_d;
         ps2_data_oe <= data_oe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      idx_d     = idx_q;
      clk_oe_d  = ps2_clk_oe;
      data_oe_d = ps2_data_oe;
      done_d    = 1'b0;
      err_d     = 1'b0;
      abort     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (tx_valid && tx_ready && locked) begin
               shift_d  = tx_data;
               parity_d = odd_parity(tx_data);
               clk_oe_d = 1'b1;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == INH_LAST) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               cnt_d     = '0;
               state_d   = REQ;
            end
         end
         REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (clk_fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = shift_q >> 1;
               idx_d     = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (clk_fall) begin
               if (idx_q == 3'd7) begin
                  data_oe_d = ~parity_q;
                  state_d   = PARITY;
               end else begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = shift_q >> 1;
                  idx_d     = idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (clk_fall) begin
               data_oe_d = 1'b0;
               state_d   = STOP;
            end
         end
         STOP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (clk_fall) begin
               if (!data_line) begin
                  state_d = ACK;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         ACK: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (clk_line && data_line) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q inside {REQ, DATA, PARITY, STOP, ACK}) && cnt_q == TMO_LAST) abort = 1'b1;
      if (state_q != IDLE && !locked) abort = 1'b1;

      if (abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
         err_d   = 1'b1;
         cnt_d   = '0;
      end

      // Returning to IDLE for any reason hands both lines back to the device.
      if (state_d == IDLE) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
      end

      ready_d = (state_d == IDLE) && locked;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector keyboard model clocking
// the bus; shortened timing parameters keep each frame to a few hundred cycles.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 40;
   localparam int TMO  = 1000;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       locked = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_in, ps2_data_in;

   int checks = 0;
   int failures = 0;
   int done_total = 0;
   int err_total = 0;
   int inh_total = 0;
   logic clk_oe_prev = 1'b0;

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .locked      (locked),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #10 clk = ~clk;

   // Pulse-high cycles and inhibit starts, tallied for whole-frame checks.
   always @(negedge clk) begin
      if (tx_done) done_total++;
      if (tx_err) err_total++;
      if (ps2_clk_oe && !clk_oe_prev) inh_total++;
      clk_oe_prev = ps2_clk_oe;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hands b to the DUT, optionally holding tx_valid high while busy, and returns
   // the inhibit length plus the data pull-down seen when the clock is released.
   task automatic send(input logic [7:0] b, input int hold, output int inh_len,
                       output logic start_low);
      int w = 0;
      while (!tx_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_send", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      check("ready_drop_after_accept", tx_ready, 0);
      tx_data  = ~b;
      tx_valid = (hold > 0);
      inh_len  = 0;
      while (ps2_clk_oe && inh_len < INH + 100) begin
         inh_len++;
         if (inh_len >= hold) tx_valid = 1'b0;
         @(negedge clk);
      end
      tx_valid  = 1'b0;
      start_low = ps2_data_oe;
   endtask

   // Keyboard: n_clk clock pulses, line sampled at the end of each low phase;
   // before pulse 11 it pulls data low when ack_low is set.
   task automatic device(input int n_clk, input bit ack_low, output logic [10:0] bits);
      bits = '0;
      tick(5);
      for (int k = 0; k < n_clk; k++) begin
         if (k == 10) begin
            dev_data_low = ack_low;
            tick(HALF / 2);
         end
         dev_clk_low = 1'b1;
         tick(HALF);
         bits[k] = ps2_data_in;
         dev_clk_low = 1'b0;
         tick(HALF);
      end
      dev_data_low = 1'b0;
   endtask

   initial begin
      int         inh_len;
      logic       start_low;
      logic [10:0] bits;
      int         d0, e0, i0, n;

      // Reset with lock already present: every output must still be low.
      locked = 1'b1;
      tick(3);
      check("reset_outputs", {tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 5'b00000);
      rst = 1'b1;
      tick(2);
      check("ready_after_reset", tx_ready, 1);

      // 0xED: full handshake with exact inhibit length.
      d0 = done_total; e0 = err_total;
      send(CMD_SET_LEDS, 0, inh_len, start_low);
      check("inhibit_len_ed", inh_len, INH);
      check("start_bit_ed", start_low, 1);
      device(11, 1'b1, bits);
      tick(10);
      check("data_ed", bits[7:0], 8'hED);
      check("parity_ed", bits[8], 1);
      check("stop_ed", bits[9], 1);
      check("done_ed", done_total - d0, 1);
      check("err_ed", err_total - e0, 0);
      check("idle_lines_ed", {ps2_clk_oe, ps2_data_oe}, 2'b00);

      // 0xF4 -> parity 0.
      d0 = done_total; e0 = err_total;
      send(CMD_ENABLE, 0, inh_len, start_low);
      device(11, 1'b1, bits);
      tick(10);
      check("data_f4", bits[7:0], 8'hF4);
      check("parity_f4", bits[8], 0);
      check("done_f4", done_total - d0, 1);

      // 0x00 -> parity 1.
      d0 = done_total;
      send(8'h00, 0, inh_len, start_low);
      device(11, 1'b1, bits);
      tick(10);
      check("data_00", bits[7:0], 8'h00);
      check("parity_00", bits[8], 1);
      check("done_00", done_total - d0, 1);

      // NACK: keyboard leaves data high on the ACK clock.
      d0 = done_total; e0 = err_total;
      send(CMD_ENABLE, 0, inh_len, start_low);
      device(11, 1'b0, bits);
      tick(10);
      check("nack_err", err_total - e0, 1);
      check("nack_done", done_total - d0, 0);
      check("nack_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      check("nack_ready", tx_ready, 1);

      // Timeout: keyboard never clocks after the release.
      d0 = done_total;
      send(8'h5A, 0, inh_len, start_low);
      n = 0;
      while (!tx_err && n < TMO + 50) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, TMO);
      check("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      @(negedge clk);
      check("timeout_err_width", tx_err, 0);
      check("timeout_ready", tx_ready, 1);
      check("timeout_done", done_total - d0, 0);

      // Lock loss in the data phase, then requests ignored until relock.
      send(CMD_SET_LEDS, 0, inh_len, start_low);
      device(4, 1'b1, bits);
      tick(5);
      locked = 1'b0;
      @(negedge clk);
      check("lock_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      check("lock_err", tx_err, 1);
      @(negedge clk);
      check("lock_err_width", tx_err, 0);
      check("lock_ready", tx_ready, 0);
      i0 = inh_total;
      tx_data  = CMD_RESET;
      tx_valid = 1'b1;
      tick(20);
      check("unlocked_ignored", inh_total - i0, 0);
      tx_valid = 1'b0;
      locked   = 1'b1;
      tick(3);
      d0 = done_total; e0 = err_total;
      send(CMD_RESET, 0, inh_len, start_low);
      device(11, 1'b1, bits);
      tick(10);
      check("data_ff", bits[7:0], 8'hFF);
      check("parity_ff", bits[8], 1);
      check("done_ff", done_total - d0, 1);
      check("err_ff", err_total - e0, 0);

      // Reset in the middle of INHIBIT.
      d0 = done_total; e0 = err_total;
      tx_data  = CMD_ENABLE;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tick(10);
      check("inhibit_active", ps2_clk_oe, 1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      rst = 1'b1;
      tick(INH + 20);
      check("rst_no_pulses", (done_total - d0) + (err_total - e0), 0);
      check("rst_ready", tx_ready, 1);

      // tx_valid held high while busy: exactly one frame, original byte.
      i0 = inh_total; d0 = done_total;
      send(8'h00, 20, inh_len, start_low);
      device(11, 1'b1, bits);
      tick(30);
      check("busy_one_frame", inh_total - i0, 1);
      check("busy_data", bits[7:0], 8'h00);
      check("busy_done", done_total - d0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
